// File: rtl/sonic_multi_if.sv
// rtl/sonic_multi_if.sv - sensor and result bundle for sonic_multi
//
// Purpose: groups the ranging enable, the sensor trigger/echo lines and the
// per-channel result bus of sonic_multi into one interface.
// Ports (signals):
//   en        ranging enable
//   echo      asynchronous sensor echo lines, one per channel
//   trig      sensor trigger lines, at most one high
//   dist_cm   last distance per channel, channel i at [i*DW +: DW]
//   valid     one-cycle pulse when a result is written
//   valid_ch  channel index written on valid
//   timeout   per-channel flag, last measurement timed out
//   stop      per-channel proximity flag with hysteresis
//   stop_any  OR of stop
// Modports: master = ranging block, slave = sensor/consumer side.

interface sonic_multi_if #(
    parameter int N_CH = 2,
    parameter int DW   = 16
);
    logic                 en;
    logic [N_CH-1:0]      echo;
    logic [N_CH-1:0]      trig;
    logic [N_CH*DW-1:0]   dist_cm;
    logic                 valid;
    logic [2:0]           valid_ch;
    logic [N_CH-1:0]      timeout;
    logic [N_CH-1:0]      stop;
    logic                 stop_any;

    modport master (
        input  en, echo,
        output trig, dist_cm, valid, valid_ch, timeout, stop, stop_any
    );

    modport slave (
        output en, echo,
        input  trig, dist_cm, valid, valid_ch, timeout, stop, stop_any
    );
endinterface

// File: rtl/sonic_multi.sv
// rtl/sonic_multi.sv - round-robin multi-channel ultrasonic ranger
//
// Purpose: triggers N_CH ultrasonic sensors one slot at a time, times the
// echo pulse in us ticks, converts it to cm (58 us per cm), and publishes
// per-channel distance, timeout and hysteretic proximity flags.
// Ports:
//   clk   single clock
//   rst   asynchronous active-low reset
//   bus   sonic_multi_if.master: en, echo in; trig, dist_cm, valid,
//         valid_ch, timeout, stop, stop_any out (all outputs registered)

module sonic_multi #(
    parameter int N_CH       = 2,
    parameter int CLK_DIV    = 100,
    parameter int TRIG_US    = 10,
    parameter int SLOT_US    = 60000,
    parameter int TIMEOUT_US = 30000,
    parameter int STOP_CM    = 40,
    parameter int HYST_CM    = 5,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    sonic_multi_if.master bus
);

    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW   = $clog2(SLOT_US + 1);

    // All-ones is reserved as the timeout marker, so the cm count stops one short.
    localparam logic [DW-1:0] CM_MAX  = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0] STOP_TH = DW'(STOP_CM);
    localparam logic [DW-1:0] REL_TH  = DW'(STOP_CM + HYST_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cur;

    logic [N_CH-1:0]     echo_s1, echo_s2, echo_d;
    logic [DIVW-1:0]     div_cnt;
    logic                tick;
    logic [SW-1:0]       slot_us;
    logic [5:0]          us58;
    logic [DW-1:0]       cm, cm_now;

    logic [N_CH-1:0]     trig_q, timeout_q, stop_q, stop_d;
    logic [DW-1:0]       dist_arr [N_CH];
    logic                valid_q, stop_any_q;
    logic [2:0]          valid_ch_q;

    logic                echo_rise, echo_fall;
    logic                trig_done, to_hit, slot_done;
    logic                start_slot, clr_meas, wr_en, wr_to, adv_cur;
    logic [DW-1:0]       wr_dist;

    // Echo synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // Free-running 1 us tick; not realigned to slots so that it never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIVW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    assign echo_rise = echo_s2[cur] & ~echo_d[cur];
    assign echo_fall = ~echo_s2[cur] & echo_d[cur];

    // Each limit fires on the tick that brings the slot count up to it.
    assign trig_done = tick && (slot_us == SW'(TRIG_US - 1));
    assign to_hit    = tick && (slot_us == SW'(TIMEOUT_US - 1));
    assign slot_done = tick && (slot_us == SW'(SLOT_US - 1));

    // The tick seen in the same cycle as the fall still belongs to the pulse,
    // so the written value includes it.
    always_comb begin
        cm_now = cm;
        if (tick && (us58 == 6'd57) && (cm != CM_MAX))
            cm_now = cm + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_slot = 1'b0;
        clr_meas   = 1'b0;
        wr_en      = 1'b0;
        wr_to      = 1'b0;
        adv_cur    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d    = TRIG;
                    start_slot = 1'b1;
                end
            end
            TRIG: begin
                if (trig_done)
                    state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (to_hit) begin
                    wr_en   = 1'b1;
                    wr_to   = 1'b1;
                    state_d = HOLD;
                end else if (echo_rise) begin
                    clr_meas = 1'b1;
                    state_d  = MEASURE;
                end
            end
            MEASURE: begin
                // A genuine fall wins over a timeout landing on the same cycle.
                if (echo_fall) begin
                    wr_en   = 1'b1;
                    state_d = HOLD;
                end else if (to_hit) begin
                    wr_en   = 1'b1;
                    wr_to   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (slot_done) begin
                    adv_cur = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_dist = wr_to ? '1 : cm_now;
        stop_d  = stop_q;
        if (wr_to)
            stop_d[cur] = 1'b0;
        else if (wr_dist <= STOP_TH)
            stop_d[cur] = 1'b1;
        else if (wr_dist > REL_TH)
            stop_d[cur] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= '0;
            slot_us    <= '0;
            us58       <= '0;
            cm         <= '0;
            trig_q     <= '0;
            timeout_q  <= '1;
            stop_q     <= '0;
            stop_any_q <= 1'b0;
            valid_q    <= 1'b0;
            valid_ch_q <= '0;
            for (int i = 0; i < N_CH; i++)
                dist_arr[i] <= '1;
        end else begin
            // Slot time runs from trigger rise until the slot ends in HOLD.
            if (start_slot)
                slot_us <= '0;
            else if (tick && (state_q != IDLE))
                slot_us <= slot_us + 1'b1;

            if (clr_meas) begin
                us58 <= '0;
                cm   <= '0;
            end else if ((state_q == MEASURE) && tick) begin
                us58 <= (us58 == 6'd57) ? 6'd0 : us58 + 6'd1;
                cm   <= cm_now;
            end

            // Driven from the next state so trig rises and falls with the state.
            trig_q  <= (state_d == TRIG) ? (N_CH'(1) << cur) : '0;
            valid_q <= wr_en;

            if (wr_en) begin
                dist_arr[cur]  <= wr_dist;
                timeout_q[cur] <= wr_to;
                stop_q         <= stop_d;
                stop_any_q     <= |stop_d;
                valid_ch_q     <= 3'(cur);
            end

            if (adv_cur)
                cur <= (cur == CW'(N_CH - 1)) ? '0 : cur + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_dist
        assign bus.dist_cm[g*DW +: DW] = dist_arr[g];
    end

    assign bus.trig     = trig_q;
    assign bus.valid    = valid_q;
    assign bus.valid_ch = valid_ch_q;
    assign bus.timeout  = timeout_q;
    assign bus.stop     = stop_q;
    assign bus.stop_any = stop_any_q;

endmodule

// File: tb/tb_sonic_multi.sv
// tb/tb_sonic_multi.sv - randomized self-checking bench for sonic_multi

module tb_sonic_multi;

    localparam int N_CH       = 2;
    localparam int CLK_DIV    = 2;
    localparam int TRIG_US    = 10;
    localparam int SLOT_US    = 3000;
    localparam int TIMEOUT_US = 2800;
    localparam int STOP_CM    = 40;
    localparam int HYST_CM    = 5;
    localparam int DW         = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sonic_multi_if #(.N_CH(N_CH), .DW(DW)) bus ();

    sonic_multi #(
        .N_CH(N_CH), .CLK_DIV(CLK_DIV), .TRIG_US(TRIG_US), .SLOT_US(SLOT_US),
        .TIMEOUT_US(TIMEOUT_US), .STOP_CM(STOP_CM), .HYST_CM(HYST_CM), .DW(DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Observation of the DUT, sampled on the falling edge.
    int                  cyc = 0;
    logic [N_CH-1:0]     trig_prev = '0;
    int                  n_rise = 0;
    int                  rise_cyc = 0;
    int                  prev_rise_cyc = 0;
    logic [N_CH-1:0]     rise_vec = '0;
    int                  n_valid = 0;
    int                  v_cyc = 0;
    logic [2:0]          v_ch = '0;
    logic [N_CH*DW-1:0]  v_dist = '0;
    logic [N_CH-1:0]     v_to = '0;
    logic [N_CH-1:0]     v_stop = '0;
    logic                v_any = 1'b0;
    logic                multi_trig = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        trig_prev <= bus.trig;
        if ($countones(bus.trig) > 1)
            multi_trig <= 1'b1;
        if ((bus.trig & ~trig_prev) != '0) begin
            n_rise        <= n_rise + 1;
            prev_rise_cyc <= rise_cyc;
            rise_cyc      <= cyc;
            rise_vec      <= bus.trig;
        end
        if (bus.valid) begin
            n_valid <= n_valid + 1;
            v_cyc   <= cyc;
            v_ch    <= bus.valid_ch;
            v_dist  <= bus.dist_cm;
            v_to    <= bus.timeout;
            v_stop  <= bus.stop;
            v_any   <= bus.stop_any;
        end
    end

    // Reference model: what each channel should report after each write.
    logic [DW-1:0] m_dist [N_CH];
    bit            m_to   [N_CH];
    bit            m_stop [N_CH];
    int            exp_nv = 0;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_dist[i] = '1;
            m_to[i]   = 1'b1;
            m_stop[i] = 1'b0;
        end
    endtask

    task automatic model_write(input int ch, input int us, input bit to);
        int d;
        exp_nv++;
        if (to) begin
            m_dist[ch] = '1;
            m_to[ch]   = 1'b1;
            m_stop[ch] = 1'b0;
        end else begin
            d = us / 58;
            if (d > (1 << DW) - 2)
                d = (1 << DW) - 2;
            m_dist[ch] = DW'(d);
            m_to[ch]   = 1'b0;
            if (d <= STOP_CM)
                m_stop[ch] = 1'b1;
            else if (d > STOP_CM + HYST_CM)
                m_stop[ch] = 1'b0;
        end
    endtask

    task automatic check_result(input int ch);
        bit any;
        any = 1'b0;
        check("valid_ch", 64'(v_ch), 64'(ch));
        for (int i = 0; i < N_CH; i++) begin
            check($sformatf("dist_cm[%0d]", i), 64'(DW'(v_dist >> (i * DW))), 64'(m_dist[i]));
            check($sformatf("timeout[%0d]", i), 64'(1'(v_to >> i)), 64'(m_to[i]));
            check($sformatf("stop[%0d]", i), 64'(1'(v_stop >> i)), 64'(m_stop[i]));
            any = any | m_stop[i];
        end
        check("stop_any", 64'(v_any), 64'(any));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trig"}, 64'(bus.trig), 64'(0));
        check({tag, "_valid"}, 64'(bus.valid), 64'(0));
        check({tag, "_valid_ch"}, 64'(bus.valid_ch), 64'(0));
        check({tag, "_dist"}, 64'(bus.dist_cm), 64'({N_CH*DW{1'b1}}));
        check({tag, "_timeout"}, 64'(bus.timeout), 64'({N_CH{1'b1}}));
        check({tag, "_stop"}, 64'(bus.stop), 64'(0));
        check({tag, "_stop_any"}, 64'(bus.stop_any), 64'(0));
    endtask

    task automatic set_echo(input int ch, input bit v);
        logic [N_CH-1:0] m;
        m = N_CH'(1) << ch;
        if (v)
            bus.echo = bus.echo | m;
        else
            bus.echo = bus.echo & ~m;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        int r0;
        int n;
        r0 = n_rise;
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            #1;
            n++;
            if (n_rise != r0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("trig_rise_seen", 64'(0), 64'(1));
    endtask

    task automatic check_trig_width();
        int w;
        w = 1;
        while (w < 4 * TRIG_US * CLK_DIV) begin
            @(negedge clk);
            #1;
            if (bus.trig == '0)
                break;
            w++;
        end
        check("trig_width_ok",
              64'(w >= (TRIG_US - 1) * CLK_DIV + 1 && w <= TRIG_US * CLK_DIV), 64'(1));
    endtask

    // kind 0: echo pulse of echo_us; 1: no echo; 2: echo stuck past timeout.
    task automatic run_slot(input int ch, input int kind, input int delay_us, input int echo_us,
                            input bit hold_pulse, input bit drop_en, input bit chk_period);
        bit ok;
        int nv0;
        int n;
        int oth;
        int fall_cyc;
        oth = (ch == 0) ? 1 : 0;
        wait_rise(2 * SLOT_US * CLK_DIV, ok);
        if (!ok)
            return;
        check("valid_count", 64'(n_valid), 64'(exp_nv));
        check("trig_vec", 64'(rise_vec), 64'(N_CH'(1) << ch));
        if (chk_period)
            check("slot_period_ok",
                  64'((rise_cyc - prev_rise_cyc) >= (SLOT_US - 1) * CLK_DIV + 2 &&
                      (rise_cyc - prev_rise_cyc) <= SLOT_US * CLK_DIV + 1), 64'(1));
        check_trig_width();
        if (drop_en)
            bus.en = 1'b0;
        nv0 = n_valid;
        fall_cyc = 0;
        if (kind != 1) begin
            wait_to(rise_cyc + delay_us * CLK_DIV);
            set_echo(ch, 1'b1);
        end
        if (kind == 0) begin
            wait_to(cyc + echo_us * CLK_DIV);
            set_echo(ch, 1'b0);
            fall_cyc = cyc;
            model_write(ch, echo_us, 1'b0);
        end else begin
            // Glitches on the channel not being ranged must be ignored.
            set_echo(oth, 1'b1);
            @(negedge clk);
            #1;
            set_echo(oth, 1'b0);
            wait_to(cyc + 40);
            set_echo(oth, 1'b1);
            wait_to(cyc + 100);
            set_echo(oth, 1'b0);
            model_write(ch, 0, 1'b1);
        end
        n = 0;
        while (n_valid == nv0 && n < TIMEOUT_US * CLK_DIV + 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("valid_seen", 64'(n_valid != nv0), 64'(1));
        if (n_valid == nv0)
            return;
        if (kind == 0)
            check("valid_latency", 64'(v_cyc - fall_cyc), 64'(3));
        else
            check("timeout_latency_ok",
                  64'((v_cyc - rise_cyc) >= (TIMEOUT_US - 1) * CLK_DIV + 1 &&
                      (v_cyc - rise_cyc) <= TIMEOUT_US * CLK_DIV), 64'(1));
        check_result(ch);
        if (kind == 2) begin
            wait_to(cyc + 100 * CLK_DIV);
            set_echo(ch, 1'b0);
        end
        if (hold_pulse) begin
            wait_to(cyc + 20 * CLK_DIV);
            set_echo(ch, 1'b1);
            wait_to(cyc + 60 * CLK_DIV);
            set_echo(ch, 1'b0);
        end
    endtask

    initial begin
        bit ok;
        int r0;
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.echo = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        check("idle_no_trig", 64'(n_rise), 64'(0));
        bus.en = 1'b1;

        run_slot(0, 0, $urandom_range(15, 100), 2320, 1'b0, 1'b0, 1'b0);
        run_slot(1, 0, $urandom_range(15, 100), $urandom_range(58, 2600), 1'b0, 1'b0, 1'b0);
        run_slot(0, 0, $urandom_range(15, 100), 2610, 1'b0, 1'b0, 1'b0);
        run_slot(1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_slot(0, 0, $urandom_range(15, 100), 2668, 1'b0, 1'b0, 1'b1);
        run_slot(1, 2, $urandom_range(15, 100), 0, 1'b0, 1'b0, 1'b0);
        run_slot(0, 0, $urandom_range(15, 100), $urandom_range(58, 2600), 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a ch1 measurement.
        wait_rise(2 * SLOT_US * CLK_DIV, ok);
        check("mid_rst_trig_vec", 64'(rise_vec), 64'(2));
        wait_to(rise_cyc + $urandom_range(15, 100) * CLK_DIV);
        set_echo(1, 1'b1);
        wait_to(cyc + 300 * CLK_DIV);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        #1;
        bus.echo = '0;
        model_reset();
        rst = 1'b1;

        // First slot after reset is ch0; en drops while it waits for echo.
        run_slot(0, 0, $urandom_range(15, 100), $urandom_range(58, 2600), 1'b0, 1'b1, 1'b0);
        r0 = n_rise;
        wait_to(rise_cyc + SLOT_US * CLK_DIV + 2000);
        check("parked_no_trig", 64'(n_rise), 64'(r0));
        check("parked_trig_low", 64'(bus.trig), 64'(0));
        bus.en = 1'b1;
        wait_rise(100, ok);
        check("resume_trig_vec", 64'(rise_vec), 64'(2));
        check("resume_valid_count", 64'(n_valid), 64'(exp_nv));
        check("one_hot_trig", 64'(multi_trig), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sonic_multi.md
SONIC_MULTI -- requirements
Module: sonic_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of ultrasonic channels, 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 100: clk cycles per 1 us tick.
REQ-003 SHALL have parameter TRIG_US, default 10: trigger pulse width in us.
REQ-004 SHALL have parameter SLOT_US, default 60000: per-channel slot length in us, measured from trigger rise.
REQ-005 SHALL have parameter TIMEOUT_US, default 30000: maximum us from trigger rise to echo fall.
REQ-006 SHALL have parameter STOP_CM, default 40, and HYST_CM, default 5: stop threshold and release hysteresis in cm.
REQ-007 SHALL have parameter DW, default 16: distance width in bits.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port en, input, 1 bit: ranging enable.
REQ-011 SHALL have port echo, input, N_CH bits: asynchronous sensor echo lines.
REQ-012 SHALL have port trig, output, N_CH bits: sensor trigger lines.
REQ-013 SHALL have port dist_cm, output, N_CH*DW bits: last distance per channel; channel i occupies bits [i*DW +: DW].
REQ-014 SHALL have port valid, output, 1 bit: one-cycle pulse when a result is written.
REQ-015 SHALL have port valid_ch, output, 3 bits: index of the channel written on valid.
REQ-016 SHALL have port timeout, output, N_CH bits: per-channel flag, set when the last measurement timed out.
REQ-017 SHALL have port stop, output, N_CH bits: per-channel proximity flag, with hysteresis.
REQ-018 SHALL have port stop_any, output, 1 bit: OR of stop.

Function
REQ-019 SHALL pass each echo bit through a 2-flop synchronizer; rise and fall SHALL be detected on the synchronized value only.
REQ-020 SHALL generate a free-running us tick, one clk cycle wide, every CLK_DIV cycles; all us timing SHALL count ticks.
REQ-021 SHALL sequence with states IDLE, TRIG, WAIT_RISE, MEASURE, HOLD; the current channel index SHALL be cur.
REQ-022 IDLE: SHALL go to TRIG with cur unchanged when en=1; SHALL stay in IDLE when en=0.
REQ-023 TRIG: SHALL drive trig[cur]=1 and all other trig bits 0 for TRIG_US ticks, then go to WAIT_RISE.
REQ-024 WAIT_RISE: SHALL go to MEASURE on echo rise and clear the us and cm counters.
REQ-025 MEASURE: SHALL increment the cm counter once per 58 ticks with echo high, with no divider.
REQ-026 The cm counter SHALL saturate at 2^DW-2; the value 2^DW-1 SHALL be reserved for timeout.
REQ-027 MEASURE: on echo fall, SHALL write dist_cm[cur]=cm, clear timeout[cur], pulse valid with valid_ch=cur on the cycle after the fall is detected, then go to HOLD.
REQ-028 In WAIT_RISE or MEASURE, when the slot counter reaches TIMEOUT_US, SHALL write dist_cm[cur]=all-ones, set timeout[cur], pulse valid, then go to HOLD.
REQ-029 HOLD: SHALL wait until the slot counter reaches SLOT_US, ignoring echo.
REQ-030 On leaving HOLD, SHALL advance cur to (cur+1) mod N_CH, wrapping from N_CH-1 to 0, then go to IDLE.
REQ-031 en=0 SHALL NOT abort a slot in progress; the slot completes, then the block parks in IDLE.
REQ-032 stop[i] SHALL set on a write with dist <= STOP_CM and not timed out.
REQ-033 stop[i] SHALL clear on a write with dist > STOP_CM+HYST_CM, or on a timeout write.
REQ-034 stop[i] SHALL hold its value on any other write.
REQ-035 stop and timeout SHALL change only on the cycle valid is asserted for that channel.
REQ-036 All outputs SHALL be registered.
REQ-037 At most one trig bit SHALL be high at any time.

Reset
REQ-038 On rst=0, asynchronously: state=IDLE, cur=0, trig=0, valid=0, valid_ch=0, dist_cm all-ones per channel, timeout all 1, stop=0, stop_any=0, synchronizers and counters 0.
REQ-039 When rst asserts mid-slot, SHALL drop trig within the same reset assertion and discard the partial measurement; the first slot after release SHALL be channel 0.

Verification
REQ-040 N_CH=2, en=1; ch0 echo high 2320 us -> valid, valid_ch=0, dist_cm[0]=40, stop[0]=1, stop_any=1.
REQ-041 Following REQ-040, ch0 echo 2610 us -> dist_cm[0]=45, stop[0] stays 1; then 2668 us -> dist_cm[0]=46, stop[0]=0.
REQ-042 Echo never rises on ch1 -> valid at 30000 us after trigger rise, dist_cm[1]=16'hFFFF, timeout[1]=1, stop[1]=0; the next ch0 trigger SHALL rise at 60000 us.
REQ-043 Echo held high beyond TIMEOUT_US -> timeout result; echo edges in HOLD and glitches on the idle channel -> no valid and no state change.
REQ-044 rst pulsed low during ch1 MEASURE -> all outputs at reset values immediately; after release the first trig is trig[0], 10 us wide.
REQ-045 en dropped during ch0 WAIT_RISE -> ch0 slot completes with its result, cur=1, then no further trig until en=1.
